// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Package     : traffic_pkg
// Description : Constants and helpers shared by the traffic-light controller
//               input blocks (toggle event receiver, input synchronisers).
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // Default depth of the toggle-line synchroniser chain.
    localparam int TOG_SYNC_STAGES_DEF = 2;

    // Default width of the pending-event counter.
    localparam int TOG_CNT_W_DEF = 4;

    // Largest value a w-bit unsigned counter can hold.
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ============================================================================
// Module      : bit_sync
// Description : N-flop synchroniser for one asynchronous input bit. All flops
//               reset to 0. Used for the toggle line and for the other
//               asynchronous inputs of the traffic controller.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync;

    // Shift chain: stage 0 samples the async input, the last stage is the
    // metastability-filtered output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync <= '0;
        end else begin
            sync <= {sync[N-2:0], d};
        end
    end

    assign q = sync[N-1];

endmodule
`default_nettype wire

// File: rtl/toggle_event_rx.sv
`default_nettype none
// ============================================================================
// Module      : toggle_event_rx
// Description : Receive end of a 2-phase toggle event link. Synchronises the
//               toggle line, turns every level change into one event, queues
//               events in a saturating counter, hands them to the consumer
//               over valid/ready and acknowledges the seen level to the
//               sender on tog_ack.
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_event_rx
    import traffic_pkg::*;
#(
    parameter int SYNC_STAGES = TOG_SYNC_STAGES_DEF,
    parameter int CNT_W       = TOG_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             tog_in,
    output logic             tog_ack,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    input  logic             ovf_clr
);

    localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

    logic s;         // synchronised toggle level
    logic prev;      // level seen by the edge detector on the previous cycle
    logic tog_edge;  // one detected, enabled event this cycle
    logic pop;       // consumer takes one event this cycle
    logic full;

    bit_sync #(
        .N (SYNC_STAGES)
    ) u_tog_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (tog_in),
        .q    (s)
    );

    // Track the synchronised level every cycle, even while capture is
    // disabled, so the sender is always acknowledged and re-enabling does not
    // produce a stale edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev <= 1'b0;
        end else begin
            prev <= s;
        end
    end

    assign tog_edge  = (s ^ prev) & en;
    assign tog_ack   = prev;
    assign evt_valid = (pending != '0);
    assign pop       = evt_valid & evt_ready;
    assign full      = (pending == PEND_MAX);

    // Pending-event counter: an event arriving in the same cycle as a pop
    // cancels out, so a full queue being drained never drops that event.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending <= '0;
        end else begin
            case ({tog_edge, pop})
                2'b10: begin
                    if (!full) begin
                        pending <= pending + PEND_ONE;
                    end
                end
                2'b01: begin
                    pending <= pending - PEND_ONE;
                end
                default: begin
                    pending <= pending;
                end
            endcase
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear wins so the
    // consumer never misses evidence of a lost event.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow <= 1'b0;
        end else if (tog_edge && !pop && full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire
